// File: rtl/ir_rx_fifo.sv
// ir_rx_fifo: IR pulse-distance frame receiver with a FIFO of decoded frames.
// The input is synchronised and de-glitched, then leader, repeat and data frames
// of programmable length are decoded. Each frame is queued as {cmp_err, repeat, data}.
// Optional feature: define IR_RX_CMP_EN to enable the address/command complement check.
module ir_rx_fifo #(
    parameter int unsigned CNT_W      = 18,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NOISE_W    = 8,
    localparam int unsigned BN_W      = $clog2(DATA_W) + 1,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sin,
    input  logic               rf_ir_phase,
    input  logic [NOISE_W-1:0] rf_noise_th,
    input  logic [CNT_W-1:0]   rf_lead_h_cnt,
    input  logic [CNT_W-1:0]   rf_lead_l_cnt,
    input  logic [CNT_W-1:0]   rf_rpt_l_cnt,
    input  logic [CNT_W-1:0]   rf_bit1_cnt,
    input  logic [CNT_W-1:0]   rf_idle_cnt,
    input  logic [BN_W-1:0]    rf_bit_num,
    input  logic               rf_cmp_en,
    input  logic               rx_pop,
    input  logic               err_clr,
    output logic               rx_valid,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_repeat,
    output logic               rx_cmp_err,
    output logic [LVL_W-1:0]   rx_level,
    output logic               ovf,
    output logic               frame_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE, LEAD_H, LEAD_L, RPT_H, DATA_H, DATA_L, STOP, PUSH
    } state_t;

    logic               s1, s2, mk, mf, mf_prev;
    logic [NOISE_W-1:0] fcnt;
    logic [CNT_W-1:0]   dur;
    logic               rise_c, fall_c, edge_c;

    state_t             state, state_nx;
    logic [DATA_W-1:0]  sr, sr_nx;
    logic [BN_W-1:0]    bit_cnt, bit_cnt_nx;
    logic               rpt, rpt_nx;
    logic               ferr_set_c, push_c, cmp_c;
    logic [BN_W-1:0]    n_eff;

    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               full_c, empty_c, pop_c, wr_c, ovf_set_c;

    // Synchroniser, phase correction and glitch filter on the mark level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            mk      <= 1'b0;
            mf      <= 1'b0;
            mf_prev <= 1'b0;
            fcnt    <= '0;
        end else begin
            s1      <= sin;
            s2      <= s1;
            mk      <= rf_ir_phase ? s2 : ~s2;
            mf_prev <= mf;
            if (mk != mf) begin
                if (fcnt == rf_noise_th) begin
                    mf   <= mk;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + NOISE_W'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign rise_c = mf & ~mf_prev;
    assign fall_c = ~mf & mf_prev;
    assign edge_c = rise_c | fall_c;

    // Duration of the current level; reloads on every edge, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            dur <= '0;
        end else if (edge_c) begin
            dur <= CNT_W'(1);
        end else if (dur != '1) begin
            dur <= dur + CNT_W'(1);
        end
    end

    // Bit count per frame; 0 or out-of-range selects the full data width.
    assign n_eff = ((rf_bit_num == '0) || (rf_bit_num > BN_W'(DATA_W))) ? BN_W'(DATA_W) : rf_bit_num;

    // Frame decoder next-state and datapath updates.
    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        bit_cnt_nx = bit_cnt;
        rpt_nx     = rpt;
        ferr_set_c = 1'b0;
        push_c     = 1'b0;
        if ((state != IDLE) && (state != PUSH) && (dur >= rf_idle_cnt)) begin
            state_nx = IDLE;
            if (state inside {DATA_H, DATA_L, STOP}) begin
                ferr_set_c = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rise_c) state_nx = LEAD_H;
                end
                LEAD_H: begin
                    if (fall_c) state_nx = (dur >= rf_lead_h_cnt) ? LEAD_L : IDLE;
                end
                LEAD_L: begin
                    if (rise_c) begin
                        if (dur >= rf_lead_l_cnt) begin
                            state_nx   = DATA_H;
                            sr_nx      = '0;
                            bit_cnt_nx = '0;
                        end else if (dur >= rf_rpt_l_cnt) begin
                            state_nx = RPT_H;
                        end else begin
                            state_nx   = IDLE;
                            ferr_set_c = 1'b1;
                        end
                    end
                end
                RPT_H: begin
                    if (fall_c) begin
                        state_nx = PUSH;
                        rpt_nx   = 1'b1;
                        sr_nx    = '0;
                    end
                end
                DATA_H: begin
                    if (fall_c) state_nx = DATA_L;
                end
                DATA_L: begin
                    if (rise_c) begin
                        for (int i = 0; i < int'(DATA_W); i++) begin
                            if (BN_W'(i) == bit_cnt) sr_nx[i] = (dur > rf_bit1_cnt);
                        end
                        bit_cnt_nx = bit_cnt + BN_W'(1);
                        state_nx   = (bit_cnt == (n_eff - BN_W'(1))) ? STOP : DATA_H;
                    end
                end
                STOP: begin
                    if (fall_c) begin
                        state_nx = PUSH;
                        rpt_nx   = 1'b0;
                    end
                end
                PUSH: begin
                    push_c   = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Decoder registers and the sticky frame error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            rpt       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            bit_cnt <= bit_cnt_nx;
            rpt     <= rpt_nx;
            if (ferr_set_c) frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

`ifdef IR_RX_CMP_EN
    // Complement check over the four bytes of a full-length data frame.
    generate
        if (DATA_W >= 32) begin : g_cmp
            assign cmp_c = rf_cmp_en & ~rpt & (n_eff >= BN_W'(32)) &
                           ((sr[7:0] != ~sr[15:8]) | (sr[23:16] != ~sr[31:24]));
        end else begin : g_no_cmp
            logic unused_cmp_en;
            assign unused_cmp_en = rf_cmp_en;
            assign cmp_c         = 1'b0;
        end
    endgenerate
`else
    logic unused_cmp_en;
    assign unused_cmp_en = rf_cmp_en;
    assign cmp_c         = 1'b0;
`endif

    assign full_c    = (count == LVL_W'(FIFO_DEPTH));
    assign empty_c   = (count == '0);
    assign pop_c     = rx_pop & ~empty_c;
    assign wr_c      = push_c & (~full_c | rx_pop);
    assign ovf_set_c = push_c & full_c & ~rx_pop;

    // FIFO pointers, level and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_c && !pop_c) count <= count + LVL_W'(1);
            else if (!wr_c && pop_c) count <= count - LVL_W'(1);
            if (ovf_set_c) ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
        end
    end

    // FIFO storage; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr] <= {cmp_c, rpt, sr};
    end

    assign rx_valid   = ~empty_c;
    assign rx_level   = count;
    assign rx_data    = empty_c ? '0 : mem[rd_ptr][DATA_W-1:0];
    assign rx_repeat  = empty_c ? 1'b0 : mem[rd_ptr][DATA_W];
    assign rx_cmp_err = empty_c ? 1'b0 : mem[rd_ptr][DATA_W+1];

endmodule

// File: tb/tb_ir_rx_fifo.sv
// Bench for ir_rx_fifo: reset values, table of data frames, repeat/glitch/overflow/
// timeout/reset sequences, then random frames and pops against a queue model.
module tb_ir_rx_fifo;

    localparam int NOISE_TH = 3;
    // Stop-mark end to PUSH cycle: filter latency (3 + noise_th), one edge cycle, then PUSH.
    localparam int POP_DLY  = 3 + NOISE_TH + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        rf_ir_phase;
    logic [7:0]  rf_noise_th;
    logic [17:0] rf_lead_h_cnt, rf_lead_l_cnt, rf_rpt_l_cnt, rf_bit1_cnt, rf_idle_cnt;
    logic [5:0]  rf_bit_num;
    logic        rf_cmp_en;
    logic        rx_pop;
    logic        err_clr;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_repeat;
    logic        rx_cmp_err;
    logic [2:0]  rx_level;
    logic        ovf;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    ir_rx_fifo #(.CNT_W(18), .DATA_W(32), .FIFO_DEPTH(4), .NOISE_W(8)) dut (
        .clk(clk), .rst(rst), .sin(sin), .rf_ir_phase(rf_ir_phase),
        .rf_noise_th(rf_noise_th), .rf_lead_h_cnt(rf_lead_h_cnt),
        .rf_lead_l_cnt(rf_lead_l_cnt), .rf_rpt_l_cnt(rf_rpt_l_cnt),
        .rf_bit1_cnt(rf_bit1_cnt), .rf_idle_cnt(rf_idle_cnt),
        .rf_bit_num(rf_bit_num), .rf_cmp_en(rf_cmp_en), .rx_pop(rx_pop),
        .err_clr(err_clr), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_repeat(rx_repeat), .rx_cmp_err(rx_cmp_err), .rx_level(rx_level),
        .ovf(ovf), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  bit_num;
        int          nsend;
        logic [31:0] payload;
        logic        cmp_en;
        logic [31:0] exp_data;
        logic        exp_cmp_on;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        rpt;
        logic        cmp;
    } ent_t;

    vec_t vecs[6];
    ent_t mq[$];
    logic m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark(input int n);
        sin = rf_ir_phase;
        cyc(n);
    endtask

    task automatic space(input int n);
        sin = ~rf_ir_phase;
        cyc(n);
    endtask

    // Leader, n bits LSB first, and the stop mark; the line is left in mark.
    task automatic send_body(input logic [63:0] bits, input int n);
        mark(900);
        space(450);
        for (int i = 0; i < n; i++) begin
            mark(56);
            space(bits[i] ? 169 : 56);
        end
        mark(56);
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n);
        send_body(bits, n);
        space(20);
    endtask

    task automatic send_repeat(input int sp);
        mark(900);
        space(sp);
        mark(56);
        space(20);
    endtask

    task automatic pop();
        rx_pop = 1'b1;
        cyc(1);
        rx_pop = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(rx_valid), 0);
        chk({tag, "_data"}, 64'(rx_data), 0);
        chk({tag, "_repeat"}, 64'(rx_repeat), 0);
        chk({tag, "_cmp"}, 64'(rx_cmp_err), 0);
        chk({tag, "_level"}, 64'(rx_level), 0);
        chk({tag, "_ovf"}, 64'(ovf), 0);
        chk({tag, "_ferr"}, 64'(frame_err), 0);
    endtask

    function automatic logic model_cmp(input logic [31:0] d, input int n, input logic r, input logic en);
`ifdef IR_RX_CMP_EN
        return en && !r && (n >= 32) &&
               ((d[7:0] != ~d[15:8]) || (d[23:16] != ~d[31:24]));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_push(input ent_t e);
        if (mq.size() < 4) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_level"}, 64'(rx_level), 64'(mq.size()));
        chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
        if (mq.size() > 0) begin
            chk({tag, "_data"}, 64'(rx_data), 64'(mq[0].data));
            chk({tag, "_repeat"}, 64'(rx_repeat), 64'(mq[0].rpt));
            chk({tag, "_cmp"}, 64'(rx_cmp_err), 64'(mq[0].cmp));
        end else begin
            chk({tag, "_data"}, 64'(rx_data), 0);
            chk({tag, "_valid"}, 64'(rx_valid), 0);
        end
    endtask

    initial begin
        int          n, op;
        logic [31:0] bits, mask;
        logic        ce;
        ent_t        e;
        logic [31:0] drain[4];
        logic        exp_cmp;

        vecs[0] = '{6'd32, 32, 32'hBA45FF00, 1'b0, 32'hBA45FF00, 1'b0};
        vecs[1] = '{6'd32, 32, 32'hBB45FF00, 1'b1, 32'hBB45FF00, 1'b1};
        vecs[2] = '{6'd24, 24, 32'hBB45FF00, 1'b1, 32'h0045FF00, 1'b0};
        vecs[3] = '{6'd8,  8,  32'h000000A5, 1'b0, 32'h000000A5, 1'b0};
        vecs[4] = '{6'd0,  32, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
        vecs[5] = '{6'd40, 32, 32'h807F01FE, 1'b1, 32'h807F01FE, 1'b0};
        drain   = '{32'd2, 32'd3, 32'd4, 32'd6};

        rst = 1'b1; rf_ir_phase = 1'b0; sin = 1'b1;
        rf_noise_th = 8'(NOISE_TH); rf_lead_h_cnt = 18'd800; rf_lead_l_cnt = 18'd400;
        rf_rpt_l_cnt = 18'd200; rf_bit1_cnt = 18'd112; rf_idle_cnt = 18'd2000;
        rf_bit_num = 6'd32; rf_cmp_en = 1'b0; rx_pop = 1'b0; err_clr = 1'b0;
        cyc(3);
        chk_all_zero("reset");
        rst = 1'b0;
        cyc(20);

        // Table of data frames: each pushes one entry, which is then popped.
        for (int k = 0; k < 6; k++) begin
            rf_bit_num = vecs[k].bit_num;
            rf_cmp_en  = vecs[k].cmp_en;
            send_frame({32'h0, vecs[k].payload}, vecs[k].nsend);
`ifdef IR_RX_CMP_EN
            exp_cmp = vecs[k].exp_cmp_on;
`else
            exp_cmp = 1'b0;
`endif
            chk($sformatf("vec%0d_valid", k), 64'(rx_valid), 1);
            chk($sformatf("vec%0d_data", k), 64'(rx_data), 64'(vecs[k].exp_data));
            chk($sformatf("vec%0d_repeat", k), 64'(rx_repeat), 0);
            chk($sformatf("vec%0d_cmp", k), 64'(rx_cmp_err), 64'(exp_cmp));
            chk($sformatf("vec%0d_level", k), 64'(rx_level), 1);
            pop();
            chk($sformatf("vec%0d_level_after_pop", k), 64'(rx_level), 0);
            chk($sformatf("vec%0d_data_after_pop", k), 64'(rx_data), 0);
        end
        rf_bit_num = 6'd32;
        rf_cmp_en  = 1'b0;

        // Repeat frame, then a too-short repeat space.
        send_repeat(225);
        chk("rpt_level", 64'(rx_level), 1);
        chk("rpt_repeat", 64'(rx_repeat), 1);
        chk("rpt_data", 64'(rx_data), 0);
        chk("rpt_ferr", 64'(frame_err), 0);
        pop();
        send_repeat(150);
        chk("badrpt_level", 64'(rx_level), 0);
        chk("badrpt_ferr", 64'(frame_err), 1);
        clr();
        chk("badrpt_ferr_clr", 64'(frame_err), 0);

        // Glitches: 3-cycle spikes are filtered, a 4-cycle spike is treated as noise.
        for (int g = 0; g < 3; g++) begin
            mark(3);
            space(50);
        end
        mark(4);
        space(50);
        chk("glitch_level", 64'(rx_level), 0);
        chk("glitch_ferr", 64'(frame_err), 0);

        // Overflow: five frames into four entries.
        rf_bit_num = 6'd8;
        for (int k = 1; k <= 5; k++) send_frame(64'(k), 8);
        chk("ovf_level", 64'(rx_level), 4);
        chk("ovf_flag", 64'(ovf), 1);
        chk("ovf_head", 64'(rx_data), 1);
        clr();
        chk("ovf_clr", 64'(ovf), 0);
        // Pop exactly in the PUSH cycle while full.
        send_body(64'd6, 8);
        sin = ~rf_ir_phase;
        cyc(POP_DLY);
        rx_pop = 1'b1;
        cyc(1);
        rx_pop = 1'b0;
        chk("poppush_level", 64'(rx_level), 4);
        chk("poppush_ovf", 64'(ovf), 0);
        chk("poppush_head", 64'(rx_data), 2);
        cyc(12);
        chk("poppush_level_late", 64'(rx_level), 4);
        chk("poppush_ovf_late", 64'(ovf), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_head", k), 64'(rx_data), 64'(drain[k]));
            pop();
        end
        chk("drain_level", 64'(rx_level), 0);
        pop();
        chk("empty_pop_level", 64'(rx_level), 0);
        chk("empty_pop_valid", 64'(rx_valid), 0);

        // Truncated frame times out with an error; the FSM must accept the next frame.
        rf_bit_num = 6'd32;
        send_repeat(225);
        send_body(64'h3FF, 10);
        space(2040);
        chk("trunc_ferr", 64'(frame_err), 1);
        chk("trunc_level", 64'(rx_level), 1);
        send_repeat(225);
        chk("after_trunc_level", 64'(rx_level), 2);
        chk("after_trunc_head", 64'(rx_repeat), 1);

        // Reset in the middle of a frame.
        mark(900);
        space(450);
        mark(56);
        space(169);
        rst = 1'b1;
        cyc(1);
        chk_all_zero("midrst");
        rst = 1'b0;
        cyc(30);

        // Random frames and pops against the queue model.
        m_ovf = 1'b0;
        for (int it = 0; it < 6; it++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                n    = int'($urandom_range(8, 12));
                bits = $urandom;
                ce   = 1'($urandom_range(0, 1));
                mask = 32'((64'd1 << n) - 64'd1);
                rf_bit_num = 6'(n);
                rf_cmp_en  = ce;
                send_frame({32'h0, bits}, n);
                e.data = bits & mask;
                e.rpt  = 1'b0;
                e.cmp  = model_cmp(bits & mask, n, 1'b0, ce);
                model_push(e);
            end else if (op == 2) begin
                send_repeat(225);
                e.data = 32'h0;
                e.rpt  = 1'b1;
                e.cmp  = 1'b0;
                model_push(e);
            end else begin
                pop();
                if (mq.size() > 0) void'(mq.pop_front());
            end
            chk_model($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
